npu_stream_feeder: RTL and testbench
====================================

// Module: npu_stream_feeder
// PURPOSE
//   AXI4-Stream transmitter that feeds the NPU slave stream input: reads an image tensor and
//   then a kernel tensor from a local tensor buffer and emits them as two packets, tagging each
//   beat with {rows, cols, num_channels} on tuser. It is the master end of the NPU input stream
//   and is used by the SoC wrapper and the testbench host model.
// PARAMETERS
//   ADDR_WIDTH          13                      tensor-buffer address and row/col field width
//   DATA_WIDTH          8                       tdata / element width (signed)
//   MAX_CHANNELS        64                      largest channel count
//   NUM_CHANNELS_WIDTH  $clog2(MAX_CHANNELS+1)  channel field width
// PORTS
//   clk           in   1                      single clock
//   rst           in   1                      asynchronous reset, active-high
//   start         in   1                      pulse: sample dims, begin transfer (ignored while busy)
//   img_row       in   ADDR_WIDTH             image rows
//   img_col       in   ADDR_WIDTH             image cols
//   ker_row       in   ADDR_WIDTH             kernel rows
//   ker_col       in   ADDR_WIDTH             kernel cols
//   num_channels  in   NUM_CHANNELS_WIDTH     channels (0 treated as 1)
//   mem_rd_en     out  1                      tensor-buffer read strobe
//   mem_rd_sel    out  1                      0 = image bank, 1 = kernel bank
//   mem_rd_addr   out  ADDR_WIDTH             element address, starts at 0 per tensor
//   mem_rd_data   in   DATA_WIDTH             read data, valid exactly 1 cycle after mem_rd_en
//   m_axis_tdata  out  DATA_WIDTH             stream data
//   m_axis_tvalid out  1                      stream valid
//   m_axis_tready in   1                      stream ready
//   m_axis_tlast  out  1                      last beat of current tensor packet
//   m_axis_tuser  out  2*ADDR_WIDTH+NUM_CHANNELS_WIDTH  {rows, cols, num_channels} of packet
//   busy          out  1                      transfer in progress
//   done          out  1                      1-cycle pulse on kernel last-beat handshake
// BEHAVIOUR
//   - Reset (async): state IDLE, all outputs 0, prefetch FIFO emptied, in-flight read discarded.
//     Reset mid-transfer aborts with no further beats; a new start is needed.
//   - FSM: IDLE -start-> SEND_IMG -last image read issued-> SEND_KER -last kernel read issued->
//     DRAIN -kernel tlast handshake-> IDLE (done=1 that cycle). busy=1 outside IDLE.
//   - Dims latched on start; tensor length N = rows*cols*max(num_channels,1), computed at
//     2*ADDR_WIDTH+NUM_CHANNELS_WIDTH bits; mem_rd_addr = low ADDR_WIDTH bits of count (wraps).
//   - Zero-length tensor (rows or cols 0): its packet is skipped entirely, no beats; if both
//     are zero, busy for 1 cycle then done pulses with no beats.
//   - Prefetch: 2-entry FIFO, each entry = {data, last, tuser}. Read issued only when
//     FIFO occupancy + in-flight reads < 2, so no entry is ever dropped.
//   - Kernel reads follow image reads with no gap; packets are back-to-back on the stream.
//   - Latency: start in cycle 0 -> mem_rd_en cycle 1 -> tvalid first asserted cycle 3.
//     With tready held 1, one beat per cycle thereafter.
//   - AXIS rules: once tvalid=1, tdata/tlast/tuser hold stable until tvalid&tready; tvalid
//     never depends on tready; beat popped only on tvalid&tready.
//   - tlast=1 on beat N-1 of each tensor; tuser constant across a packet.
//   - start while busy: ignored, latched dims unchanged.
// TESTING
//   - img 3x3x1, ker 2x2x1, tready=1 -> 9 beats tuser={3,3,1}, tlast on 9th; 4 beats
//     tuser={2,2,1}, tlast on 4th; first tvalid 3 cycles after start; done 1 cycle, 13 beats total.
//   - Same, tready toggled 1010... and random -> identical data order, tdata stable when
//     stalled, no lost/duplicate beats, mem_rd_en never outstanding beyond FIFO space.
//   - num_channels=0, img 2x2 -> 4 image beats with tuser channel field 0; ker 1x1 -> 1 beat tlast.
//   - img_row=0 -> no image beats, kernel packet only; both zero -> done, no tvalid.
//   - rst asserted mid-image with tvalid=1 -> tvalid, busy drop immediately; new start resends from addr 0.
//   - start pulsed again while busy with different dims -> ignored; original packets unchanged.

Source files
------------

// File: rtl/npu_stream_feeder.sv
// rtl/npu_stream_feeder.sv - tensor-buffer to AXI4-Stream feeder (image packet then kernel packet)
module npu_stream_feeder #(
  parameter int ADDR_WIDTH         = 13,
  parameter int DATA_WIDTH         = 8,
  parameter int MAX_CHANNELS       = 64,
  parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [ADDR_WIDTH-1:0]                       img_row,
  input  logic [ADDR_WIDTH-1:0]                       img_col,
  input  logic [ADDR_WIDTH-1:0]                       ker_row,
  input  logic [ADDR_WIDTH-1:0]                       ker_col,
  input  logic [NUM_CHANNELS_WIDTH-1:0]               num_channels,
  output logic                                        mem_rd_en,
  output logic                                        mem_rd_sel,
  output logic [ADDR_WIDTH-1:0]                       mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]                       mem_rd_data,
  output logic [DATA_WIDTH-1:0]                       m_axis_tdata,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic                                        m_axis_tlast,
  output logic [2*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1:0]  m_axis_tuser,
  output logic                                        busy,
  output logic                                        done
);

  localparam int LW = 2*ADDR_WIDTH + NUM_CHANNELS_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_SEND_IMG, S_SEND_KER, S_DRAIN} state_t;

  state_t                  r_state, w_next;
  logic [LW-1:0]           r_img_len, r_ker_len, r_img_user, r_ker_user, r_cnt;
  logic [NUM_CHANNELS_WIDTH-1:0] w_ch;
  logic [LW-1:0]           w_img_len, w_ker_len, w_cur_len;
  logic                    w_last_rd, w_issue, w_pop, w_drained;
  logic                    r_inflight, r_rd_last, r_rd_ker;
  logic [DATA_WIDTH-1:0]   r_fd [2];
  logic                    r_fl [2];
  logic [LW-1:0]           r_fu [2];
  logic                    r_wptr, r_rptr;
  logic [1:0]              r_count;
  logic [2:0]              w_occ;

  // A channel count of zero still means one element per pixel.
  assign w_ch      = (num_channels == '0) ? NUM_CHANNELS_WIDTH'(1) : num_channels;
  assign w_img_len = LW'(img_row) * LW'(img_col) * LW'(w_ch);
  assign w_ker_len = LW'(ker_row) * LW'(ker_col) * LW'(w_ch);
  assign w_cur_len = (r_state == S_SEND_KER) ? r_ker_len : r_img_len;
  assign w_last_rd = (r_cnt == w_cur_len - LW'(1));

  // Occupancy counts the beat leaving this cycle, so a full-rate stream keeps one read per cycle.
  assign w_pop     = m_axis_tvalid & m_axis_tready;
  assign w_occ     = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_drained = !r_inflight && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

  assign m_axis_tvalid = (r_count != 2'd0);
  assign m_axis_tdata  = r_fd[r_rptr];
  assign m_axis_tlast  = r_fl[r_rptr];
  assign m_axis_tuser  = r_fu[r_rptr];
  assign mem_rd_en     = w_issue;
  assign mem_rd_sel    = (r_state == S_SEND_KER);
  assign mem_rd_addr   = w_issue ? r_cnt[ADDR_WIDTH-1:0] : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state, read issue and status; zero-length tensors are skipped at start.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    done    = 1'b0;
    busy    = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_img_len != '0)      w_next = S_SEND_IMG;
          else if (w_ker_len != '0) w_next = S_SEND_KER;
          else                      w_next = S_DRAIN;
        end
      end
      S_SEND_IMG: begin
        w_issue = (w_occ < 3'd2);
        if (w_issue && w_last_rd) w_next = (r_ker_len != '0) ? S_SEND_KER : S_DRAIN;
      end
      S_SEND_KER: begin
        w_issue = (w_occ < 3'd2);
        if (w_issue && w_last_rd) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drained) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch dimensions on an accepted start; step the element counter per read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_img_len  <= '0;
      r_ker_len  <= '0;
      r_img_user <= '0;
      r_ker_user <= '0;
      r_cnt      <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_img_len  <= w_img_len;
      r_ker_len  <= w_ker_len;
      r_img_user <= {img_row, img_col, num_channels};
      r_ker_user <= {ker_row, ker_col, num_channels};
      r_cnt      <= '0;
    end else if (w_issue) begin
      r_cnt <= w_last_rd ? '0 : r_cnt + LW'(1);
    end
  end

  // Tag each outstanding read so its entry carries the right last flag and tuser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_ker   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_rd_last  <= w_issue & w_last_rd;
      r_rd_ker   <= (r_state == S_SEND_KER);
    end
  end

  // Two-entry prefetch FIFO: write on returning read data, pop on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_fd[i] <= '0;
        r_fl[i] <= 1'b0;
        r_fu[i] <= '0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_fd[r_wptr] <= mem_rd_data;
        r_fl[r_wptr] <= r_rd_last;
        r_fu[r_wptr] <= r_rd_ker ? r_ker_user : r_img_user;
        r_wptr       <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
    end
  end

endmodule

// File: tb/tb_npu_stream_feeder.sv
// tb/tb_npu_stream_feeder.sv - self-checking bench for npu_stream_feeder
module tb_npu_stream_feeder;
  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int NCW = 7;
  localparam int UW  = 2*AW + NCW;

  logic clk = 1'b0;
  logic rst, start;
  logic [AW-1:0]  img_row, img_col, ker_row, ker_col;
  logic [NCW-1:0] num_channels;
  logic           mem_rd_en, mem_rd_sel;
  logic [AW-1:0]  mem_rd_addr;
  logic [DW-1:0]  mem_rd_data = '0;
  logic [DW-1:0]  m_axis_tdata;
  logic           m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [UW-1:0]  m_axis_tuser;
  logic           busy, done;

  always #5 clk = ~clk;

  npu_stream_feeder dut (
    .clk(clk), .rst(rst), .start(start),
    .img_row(img_row), .img_col(img_col), .ker_row(ker_row), .ker_col(ker_col),
    .num_channels(num_channels),
    .mem_rd_en(mem_rd_en), .mem_rd_sel(mem_rd_sel), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .done(done)
  );

  // Tensor buffer model: one-cycle read latency.
  logic [DW-1:0] img_mem [0:8191];
  logic [DW-1:0] ker_mem [0:8191];
  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= mem_rd_sel ? ker_mem[mem_rd_addr] : img_mem[mem_rd_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  typedef struct {
    int ir, ic, kr, kc, nch;
    int mode;       // 0 tready high, 1 toggling, 2 random
    int restart;    // cycle at which a second start is pulsed (0 = none)
    int exp_n;      // total beats
    int exp_first;  // first tvalid cycle, -1 never, -2 unchecked
    int exp_done;   // done cycle, -2 unchecked
  } vec_t;

  // Reference: a tensor is rows*cols*max(ch,1) elements read from address 0 upward.
  task automatic add_packet(inout beat_t q[$], input int rows, input int cols, input int ch,
                            input bit ker);
    int n;
    beat_t b;
    n = rows * cols * ((ch == 0) ? 1 : ch);
    for (int i = 0; i < n; i++) begin
      b.d = ker ? ker_mem[i % 8192] : img_mem[i % 8192];
      b.l = (i == n - 1);
      b.u = {AW'(rows), AW'(cols), NCW'(ch)};
      q.push_back(b);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    beat_t expq[$];
    beat_t act;
    int got = 0, first_v = -1, first_rd = -1, done_cyc = -1;
    int issued = 0, popped = 0, max_out = 0, budget;
    bit stable_bad = 0, idle_bad = 0, pv = 0, pr = 0;
    logic [DW-1:0] pd = '0;
    logic pl = 1'b0;
    logic [UW-1:0] pu = '0;
    add_packet(expq, v.ir, v.ic, v.nch, 1'b0);
    add_packet(expq, v.kr, v.kc, v.nch, 1'b1);
    budget = 64 + 4 * expq.size();
    @(posedge clk); #1;
    start = 1'b1;
    img_row = AW'(v.ir); img_col = AW'(v.ic);
    ker_row = AW'(v.kr); ker_col = AW'(v.kc);
    num_channels = NCW'(v.nch);
    m_axis_tready = 1'b1;
    for (int j = 1; j <= budget && done_cyc < 0; j++) begin
      @(posedge clk); #1;
      start = (j == v.restart);
      img_row = AW'($urandom_range(1, 7)); img_col = AW'($urandom_range(1, 7));
      ker_row = AW'($urandom_range(1, 7)); ker_col = AW'($urandom_range(1, 7));
      num_channels = NCW'($urandom_range(1, 5));
      case (v.mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = j[0];
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (mem_rd_en) begin
        issued++;
        if (first_rd < 0) first_rd = j;
      end
      if (m_axis_tvalid && first_v < 0) first_v = j;
      if (pv && !pr && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl ||
                        m_axis_tuser !== pu)) stable_bad = 1;
      if (m_axis_tvalid && m_axis_tready) begin
        popped++;
        if (got < expq.size()) begin
          act.d = m_axis_tdata; act.l = m_axis_tlast; act.u = m_axis_tuser;
          chk($sformatf("%s_beat%0d", tag, got), {act.d, act.l, act.u},
              {expq[got].d, expq[got].l, expq[got].u});
        end
        got++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      pv = m_axis_tvalid; pr = m_axis_tready;
      pd = m_axis_tdata;  pl = m_axis_tlast; pu = m_axis_tuser;
      if (done) done_cyc = j;
    end
    start = 1'b0;
    chk({tag, "_timeout"}, 64'(done_cyc >= 0), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      m_axis_tready = 1'b1;
      @(negedge clk);
      if (m_axis_tvalid || busy || done) idle_bad = 1;
    end
    chk({tag, "_count"}, 64'(got), 64'(v.exp_n));
    chk({tag, "_model_len"}, 64'(expq.size()), 64'(v.exp_n));
    if (v.exp_first != -2) chk({tag, "_first_tvalid"}, 64'(first_v), 64'(v.exp_first));
    if (v.exp_first > 0)   chk({tag, "_first_rd"}, 64'(first_rd), 64'd1);
    if (v.exp_done != -2)  chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
    chk({tag, "_stable"}, 64'(stable_bad), 64'd0);
    chk({tag, "_outstanding"}, 64'(max_out <= 2), 64'd1);
    chk({tag, "_idle_after"}, 64'(idle_bad), 64'd0);
  endtask

  vec_t vt[8];
  vec_t rv;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      img_mem[i] = DW'($urandom);
      ker_mem[i] = DW'($urandom);
    end
    //          ir ic kr kc nch mode rst  n  first done
    vt[0] = '{3, 3, 2, 2, 1, 0, 0, 13,  3, 15};
    vt[1] = '{3, 3, 2, 2, 1, 1, 0, 13,  3, -2};
    vt[2] = '{3, 3, 2, 2, 1, 2, 0, 13,  3, -2};
    vt[3] = '{2, 2, 1, 1, 0, 0, 0,  5,  3,  7};
    vt[4] = '{0, 5, 2, 2, 1, 0, 0,  4,  3,  6};
    vt[5] = '{0, 0, 0, 3, 2, 0, 0,  0, -1,  1};
    vt[6] = '{2, 3, 3, 1, 2, 0, 4, 18,  3, 20};
    vt[7] = '{3, 2, 0, 0, 4, 1, 0, 24,  3, -2};

    rst = 1'b1; start = 1'b0; m_axis_tready = 1'b1;
    img_row = '0; img_col = '0; ker_row = '0; ker_col = '0; num_channels = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {m_axis_tvalid, busy, done, mem_rd_en, m_axis_tlast, m_axis_tdata},
        '0);
    chk("reset_tuser", 64'(m_axis_tuser), 64'd0);

    for (int i = 0; i < 8; i++) run_txn(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of the image packet, then a clean resend from address 0.
    @(posedge clk); #1;
    start = 1'b1; img_row = 4; img_col = 4; ker_row = 1; ker_col = 1; num_channels = 1;
    m_axis_tready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk("midrst_pre_valid", 64'(m_axis_tvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid_busy", {m_axis_tvalid, busy, mem_rd_en}, 3'b000);
    @(posedge clk); #1 rst = 1'b0;
    rv = '{4, 4, 1, 1, 1, 0, 0, 17, 3, 19};
    run_txn(rv, "after_rst");

    // Randomized transfers against the reference model.
    for (int t = 0; t < 12; t++) begin
      rv.ir = $urandom_range(0, 4); rv.ic = $urandom_range(0, 4);
      rv.kr = $urandom_range(0, 4); rv.kc = $urandom_range(0, 4);
      rv.nch = $urandom_range(0, 4);
      rv.mode = $urandom_range(0, 2);
      rv.restart = (t % 3 == 0) ? 2 : 0;
      rv.exp_n = (rv.ir * rv.ic + rv.kr * rv.kc) * ((rv.nch == 0) ? 1 : rv.nch);
      rv.exp_first = (rv.exp_n > 0) ? 3 : -1;
      rv.exp_done = (rv.mode == 0) ? ((rv.exp_n == 0) ? 1 : rv.exp_n + 2) : -2;
      run_txn(rv, $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
